// File: rtl/compositor_pkg.sv
// rtl/compositor_pkg.sv - shared types and constants for the OLED layer compositor
package compositor_pkg;

  localparam int COLOUR_W      = 16;
  localparam int PIXEL_INDEX_W = 13;
  localparam int OLED_W        = 96;
  localparam int OLED_H        = 64;

  typedef logic [COLOUR_W-1:0] rgb565_t;

  localparam rgb565_t COL_BLACK = 16'h0000;
  localparam rgb565_t COL_WHITE = 16'hFFFF;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_flash_ctr.sv
// rtl/layer_flash_ctr.sv - per-layer flash down-counter, counts frames
// A new request always restarts the count, even on a frame boundary.
module layer_flash_ctr #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_frame_begin,
  input  logic       i_flash_req,
  output logic [7:0] o_cnt
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 8'd0;
    end else if (i_flash_req) begin
      r_cnt <= 8'(FLASH_FRAMES);
    end else if (i_frame_begin && (r_cnt != 8'd0)) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/layer_compositor.sv
// rtl/layer_compositor.sv - N-layer priority compositor, two-stage pipeline, index-aligned output
// Optional per-layer hit-flash is built when LAYER_COMPOSITOR_FLASH_EN is defined.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int      NUM_LAYERS      = 4,
  parameter rgb565_t TRANSPARENT_KEY = COL_BLACK,
  parameter rgb565_t BG_COLOUR       = COL_BLACK,
  parameter int      FLASH_FRAMES    = 8,
  parameter rgb565_t FLASH_COLOUR    = COL_WHITE,
  localparam int     IDX_W           = idx_width(NUM_LAYERS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_begin,
  input  logic                           in_valid,
  input  logic [PIXEL_INDEX_W-1:0]       pixel_index_in,
  input  logic [NUM_LAYERS*COLOUR_W-1:0] layer_col,
  input  logic [NUM_LAYERS-1:0]          layer_en_req,
  input  logic [NUM_LAYERS-1:0]          flash_req,
  output logic                           out_valid,
  output logic [PIXEL_INDEX_W-1:0]       pixel_index_out,
  output rgb565_t                        pixel_data,
  output logic [IDX_W-1:0]               hit_layer,
  output logic                           hit_bg
);

  logic [NUM_LAYERS-1:0]          r_en_q;
  logic [NUM_LAYERS-1:0]          w_opaque;
  logic [NUM_LAYERS*COLOUR_W-1:0] w_col_eff;
  logic [NUM_LAYERS-1:0]          r_opaque;
  logic [NUM_LAYERS*COLOUR_W-1:0] r_col;
  logic [PIXEL_INDEX_W-1:0]       r_idx;
  logic                           r_vld;
  rgb565_t                        w_pix;
  logic [IDX_W-1:0]               w_win;
  logic                           w_any;

  // Mask changes land only on frame boundaries so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_q <= '1;
    end else if (frame_begin) begin
      r_en_q <= layer_en_req;
    end
  end

  always_comb begin
    w_opaque = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      w_opaque[k] = r_en_q[k] && (layer_col[k*COLOUR_W +: COLOUR_W] != TRANSPARENT_KEY);
    end
  end

`ifdef LAYER_COMPOSITOR_FLASH_EN
  // Flash swaps colour only; opacity above is still taken from the raw colour.
  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_flash
    logic [7:0] w_cnt;
    layer_flash_ctr #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash_ctr (
      .clk          (clk),
      .reset        (reset),
      .i_frame_begin(frame_begin),
      .i_flash_req  (flash_req[g]),
      .o_cnt        (w_cnt)
    );
    assign w_col_eff[g*COLOUR_W +: COLOUR_W] =
      w_cnt[0] ? FLASH_COLOUR : layer_col[g*COLOUR_W +: COLOUR_W];
  end
`else
  assign w_col_eff = layer_col;
  logic w_unused_flash;
  assign w_unused_flash = ^{flash_req, FLASH_FRAMES[7:0], FLASH_COLOUR};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_opaque <= '0;
      r_col    <= '0;
      r_idx    <= '0;
      r_vld    <= 1'b0;
    end else begin
      r_opaque <= w_opaque;
      r_col    <= w_col_eff;
      r_idx    <= pixel_index_in;
      r_vld    <= in_valid;
    end
  end

  // Scan from the lowest priority upward so the lowest opaque index wins.
  always_comb begin
    w_any = 1'b0;
    w_win = IDX_W'(NUM_LAYERS - 1);
    w_pix = BG_COLOUR;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (r_opaque[k]) begin
        w_any = 1'b1;
        w_win = IDX_W'(k);
        w_pix = r_col[k*COLOUR_W +: COLOUR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid       <= 1'b0;
      pixel_index_out <= '0;
      pixel_data      <= '0;
      hit_layer       <= IDX_W'(NUM_LAYERS - 1);
      hit_bg          <= 1'b1;
    end else begin
      out_valid       <= r_vld;
      pixel_index_out <= r_idx;
      pixel_data      <= w_pix;
      hit_layer       <= w_win;
      hit_bg          <= ~w_any;
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// tb/tb_layer_compositor.sv - scoreboard bench for layer_compositor with a frame-level reference model
module tb_layer_compositor;

  localparam int          N        = 4;
  localparam logic [15:0] BG       = 16'h1234;
  localparam logic [15:0] FLASH_C  = 16'hFFFF;
  localparam int          FFRAMES  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_begin = 1'b0;
  logic        in_valid = 1'b0;
  logic [12:0] pixel_index_in = '0;
  logic [63:0] layer_col = '0;
  logic [3:0]  layer_en_req = '1;
  logic [3:0]  flash_req = '0;
  logic        out_valid;
  logic [12:0] pixel_index_out;
  logic [15:0] pixel_data;
  logic [1:0]  hit_layer;
  logic        hit_bg;

  layer_compositor #(
    .NUM_LAYERS     (N),
    .TRANSPARENT_KEY(16'h0000),
    .BG_COLOUR      (BG),
    .FLASH_FRAMES   (FFRAMES),
    .FLASH_COLOUR   (FLASH_C)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_begin    (frame_begin),
    .in_valid       (in_valid),
    .pixel_index_in (pixel_index_in),
    .layer_col      (layer_col),
    .layer_en_req   (layer_en_req),
    .flash_req      (flash_req),
    .out_valid      (out_valid),
    .pixel_index_out(pixel_index_out),
    .pixel_data     (pixel_data),
    .hit_layer      (hit_layer),
    .hit_bg         (hit_bg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [12:0] idx;
    logic [15:0] data;
    logic [1:0]  hit;
    logic        bg;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   rst_chk_cyc = -1;

  // Reference state: the frame-latched mask and flash counters, in frame terms.
  logic [3:0] m_en = 4'b1111;
  int         m_cnt[4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_pixel(input logic [63:0] cols, output logic [15:0] d,
                             output logic [1:0] h, output logic b);
    d = BG; h = 2'(N - 1); b = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      if (m_en[k] && cols[k*16 +: 16] != 16'h0000) begin
        d = cols[k*16 +: 16];
`ifdef LAYER_COMPOSITOR_FLASH_EN
        if (m_cnt[k] % 2 == 1) d = FLASH_C;
`endif
        h = 2'(k); b = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit vld, input logic [12:0] idx, input logic [63:0] cols,
                       input bit fb, input logic [3:0] enr, input logic [3:0] fr, input bit rst,
                       input bit ov = 1'b0, input logic [15:0] ov_d = '0,
                       input logic [1:0] ov_h = '0, input bit ov_b = 1'b0);
    exp_t e;
    @(posedge clk); #2;
    reset = rst; in_valid = vld; pixel_index_in = idx; layer_col = cols;
    frame_begin = fb; layer_en_req = enr; flash_req = fr;
    if (rst) begin
      while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
      rst_chk_cyc = cyc + 1;
      m_en = 4'b1111;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
    end else begin
      if (vld) begin
        e.cyc = cyc + 2; e.idx = idx;
        model_pixel(cols, e.data, e.hit, e.bg);
        if (ov) begin e.data = ov_d; e.hit = ov_h; e.bg = ov_b; end
        sb.push_back(e);
      end
      if (fb) m_en = enr;
      for (int k = 0; k < N; k++) begin
        if (fr[k]) m_cnt[k] = FFRAMES;
        else if (fb && m_cnt[k] > 0) m_cnt[k] = m_cnt[k] - 1;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (cyc == rst_chk_cyc) begin
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_pixel_data", 32'(pixel_data), 0);
        chk("rst_index", 32'(pixel_index_out), 0);
        chk("rst_hit_layer", 32'(hit_layer), N - 1);
        chk("rst_hit_bg", 32'(hit_bg), 1);
      end
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL dropped idx=%0d expected_cycle=%0d now=%0d", sb[0].idx, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (out_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_valid idx=%0d cycle=%0d", pixel_index_out, cyc);
        end else begin
          e = sb.pop_front();
          chk("latency", 32'(cyc), 32'(e.cyc));
          chk("pixel_index_out", 32'(pixel_index_out), 32'(e.idx));
          chk("pixel_data", 32'(pixel_data), 32'(e.data));
          chk("hit_layer", 32'(hit_layer), 32'(e.hit));
          chk("hit_bg", 32'(hit_bg), 32'(e.bg));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [63:0] cols;
    logic [63:0] vec1 = {16'h001F, 16'hF800, 16'h07E0, 16'h0000};
    logic [63:0] red0 = {16'h0000, 16'h0000, 16'h0000, 16'hF800};
    for (int i = 0; i < 3; i++) drive(0, 0, '0, 0, 4'hF, 4'h0, 1);

    drive(1, 13'd100, vec1, 0, 4'hF, 4'h0, 0, 1, 16'h07E0, 2'd1, 1'b0);
    drive(1, 13'd101, '0, 0, 4'hF, 4'h0, 0, 1, 16'h1234, 2'd3, 1'b1);
    drive(0, 13'd102, '0, 0, 4'hF, 4'h0, 0);

    drive(1, 13'd10, vec1, 1, 4'hF, 4'h0, 0, 1, 16'h07E0, 2'd1, 1'b0);
    drive(1, 13'd11, vec1, 0, 4'b1101, 4'h0, 0, 1, 16'h07E0, 2'd1, 1'b0);
    drive(1, 13'd12, vec1, 0, 4'b1101, 4'h0, 0, 1, 16'h07E0, 2'd1, 1'b0);
    drive(1, 13'd13, vec1, 1, 4'b1101, 4'h0, 0, 1, 16'h07E0, 2'd1, 1'b0);
    drive(1, 13'd14, vec1, 0, 4'b1101, 4'h0, 0, 1, 16'hF800, 2'd2, 1'b0);
    drive(1, 13'd15, vec1, 0, 4'hF, 4'h0, 0, 1, 16'hF800, 2'd2, 1'b0);
    drive(0, 13'd0, '0, 1, 4'hF, 4'h0, 0);

`ifdef LAYER_COMPOSITOR_FLASH_EN
    drive(1, 13'd20, red0, 0, 4'hF, 4'h1, 0, 1, 16'hF800, 2'd0, 1'b0);
    drive(1, 13'd21, red0, 1, 4'hF, 4'h0, 0, 1, 16'hFFFF, 2'd0, 1'b0);
    drive(1, 13'd22, red0, 1, 4'hF, 4'h0, 0, 1, 16'hF800, 2'd0, 1'b0);
    drive(1, 13'd23, red0, 1, 4'hF, 4'h0, 0, 1, 16'hFFFF, 2'd0, 1'b0);
    drive(1, 13'd24, red0, 1, 4'hF, 4'h0, 0, 1, 16'hF800, 2'd0, 1'b0);
    drive(1, 13'd25, red0, 1, 4'hF, 4'h1, 0, 1, 16'hF800, 2'd0, 1'b0);
    drive(1, 13'd26, red0, 1, 4'hF, 4'h0, 0, 1, 16'hFFFF, 2'd0, 1'b0);
    drive(1, 13'd27, red0, 0, 4'hF, 4'h0, 0, 1, 16'hF800, 2'd0, 1'b0);
`else
    drive(1, 13'd20, red0, 0, 4'hF, 4'h1, 0, 1, 16'hF800, 2'd0, 1'b0);
    drive(1, 13'd21, red0, 1, 4'hF, 4'h0, 0, 1, 16'hF800, 2'd0, 1'b0);
`endif

    for (int i = 0; i < 6144; i++) begin
      for (int k = 0; k < N; k++)
        cols[k*16 +: 16] = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      drive(($urandom_range(0, 3) != 0), 13'(i), cols, (i % 256 == 0),
            4'($urandom), ($urandom_range(0, 31) == 0) ? 4'($urandom) : 4'h0,
            (i == 3000));
    end

    for (int i = 0; i < 4; i++) drive(0, 0, '0, 0, 4'hF, 4'h0, 0);
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_compositor.md
# layer_compositor

Parametrised, pipelined pixel compositor for the 96x64 OLED path. It sits between the per-layer colour generators (status bar, sprites, background, …) and `Oled_Display`. It replaces the fixed four-way priority mux with an N-layer priority encoder that has a configurable transparency key and per-layer enables that update only on frame boundaries. An optional per-layer hit-flash effect is also provided. Output is registered and index-aligned, so `pixel_data` always matches the `pixel_index` it was computed for.

## Interface
Parameters:
- `NUM_LAYERS`, 4: layer count, ≥2. Layer 0 has highest priority.
- `TRANSPARENT_KEY`, 16'h0000: RGB565 value treated as "no pixel".
- `BG_COLOUR`, 16'h0000: output when no enabled layer is opaque.
- `FLASH_FRAMES`, 8: frames a flash lasts, 1..255 (only with the macro).
- `FLASH_COLOUR`, 16'hFFFF: colour substituted on flash-on frames (only with the macro).

Ports:
- `clk` in 1: system clock (6.25 MHz OLED domain).
- `reset` in 1: synchronous, active-high.
- `frame_begin` in 1: one-cycle pulse from `Oled_Display`.
- `in_valid` in 1: qualifies the pixel inputs (driven from `sample_pixel`).
- `pixel_index_in` in 13: index of the current pixel.
- `layer_col` in NUM_LAYERS*16: packed colours. Layer k occupies bits [16k+15:16k].
- `layer_en_req` in NUM_LAYERS: requested enable mask, sampled at `frame_begin`.
- `flash_req` in NUM_LAYERS: per-layer one-cycle flash trigger.
- `out_valid` out 1: output qualifier.
- `pixel_index_out` out 13: the `pixel_index_in` that produced `pixel_data`.
- `pixel_data` out 16: composited RGB565.
- `hit_layer` out IDX_W: winning layer index. IDX_W = max(1, clog2(NUM_LAYERS)). Equals NUM_LAYERS-1 when `BG_COLOUR` is output.
- `hit_bg` out 1: high when `BG_COLOUR` was output.

## Operation
- Enable shadow `en_q`:
  - Loads `layer_en_req` on the cycle `frame_begin`=1.
  - Holds otherwise, so mid-frame changes take effect next frame.
  - Reset value is all ones.
- Layer k is opaque when `en_q[k]` is set and `layer_col[k] != TRANSPARENT_KEY`.
- Winner is the lowest opaque index.
- If no layer is opaque:
  - `pixel_data` = `BG_COLOUR`.
  - `hit_layer` = NUM_LAYERS-1.
  - `hit_bg` = 1.
- Stage 1 registers:
  - the per-layer opaque vector,
  - the input colours,
  - `pixel_index_in`,
  - `in_valid`.
- Stage 2 does the priority encode and colour select, then registers the outputs.
- Pipeline advances every cycle. There is no stall: `in_valid` only travels with its data.
- When `in_valid`=0, the stage data registers still load, but `out_valid` follows the delayed `in_valid`.
- Reset values:
  - `out_valid` = 0, `pixel_index_out` = 0, `pixel_data` = 0.
  - `hit_layer` = NUM_LAYERS-1, `hit_bg` = 1.
  - Stage-1 registers cleared.
  - Flash counters 0.
- Reset mid-frame:
  - outputs return to reset values on the next edge;
  - in-flight pixels are discarded;
  - the enable shadow returns to all ones.

## Timing
- Latency: 2 clk from `pixel_index_in`/`layer_col` to `pixel_data`/`pixel_index_out`. Fixed, independent of NUM_LAYERS.
- `en_q` updated at the `frame_begin` edge applies to pixels entering stage 1 on the following cycle.
- Throughput: one pixel per clk.

## Configuration
- Macro `LAYER_COMPOSITOR_FLASH_EN`. When defined:
  - Each layer has an 8-bit down-counter `flash_cnt[k]`.
  - `flash_req[k]`=1 loads FLASH_FRAMES. A re-request restarts the count.
  - `frame_begin` decrements a nonzero counter.
  - If `flash_req` and `frame_begin` coincide, the load wins and no decrement happens that cycle.
  - While `flash_cnt[k]` is nonzero and odd, opaque pixels of layer k output `FLASH_COLOUR`. Priority is unchanged.
  - Flash does not make transparent pixels opaque.
- When undefined:
  - `flash_req` is ignored.
  - No counters are built.
  - Colour is always `layer_col[k]`.

## Structure
- Package `compositor_pkg`:
  - RGB565 typedef `rgb565_t`.
  - `COLOUR_W`=16, `PIXEL_INDEX_W`=13, `OLED_W`=96, `OLED_H`=64.
  - Named colour constants (`COL_BLACK`, `COL_WHITE`).
- Sub-module `layer_flash_ctr`:
  - one flash counter with its load/decrement rule;
  - instantiated NUM_LAYERS times inside a generate under the macro.

## Test plan
- NUM_LAYERS=4, all enabled, `layer_col` = {16'h0000, 16'h07E0, 16'hF800, 16'h001F} for layers 0..3, index 100 → two clk later: `pixel_data`=16'h07E0, `hit_layer`=1, `pixel_index_out`=100, `out_valid`=1.
- All layers 16'h0000, BG_COLOUR=16'h1234 → `pixel_data`=16'h1234, `hit_bg`=1, `hit_layer`=3.
- `layer_en_req`=4'b1101 applied mid-frame with layer 1 opaque:
  - before the next `frame_begin`, layer 1 still wins;
  - from two clk after `frame_begin` onward, layer 2 wins.
- Streaming of indices 0..6143 with `in_valid` toggled → `pixel_index_out` and `out_valid` equal the input delayed by exactly 2 clk. No drops.
- With the macro, FLASH_FRAMES=3, `flash_req[0]` pulse, layer 0 = 16'hF800:
  - outputs 16'hFFFF, F800, FFFF, then F800 steady on successive frames;
  - a `flash_req` coinciding with `frame_begin` reloads to 3.
- `reset` asserted for 1 clk mid-stream → next cycle `out_valid`=0, `pixel_data`=0, `hit_layer`=3, `en_q`=4'b1111, flash counters 0.
